sd_block_arbiter: RTL and testbench
===================================

SD_BLOCK_ARBITER -- requirements
Module: sd_block_arbiter

Interface
REQ-001 SHALL have parameter WORDS_PER_BLOCK, default 128, meaning the number of iWordReady pulses per block read.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1048576, meaning the watchdog limit in iCLK cycles.
REQ-003 SHALL have port iCLK  input  1  meaning the single clock; every register is clocked on the rising edge.
REQ-004 SHALL have port Reset  input  1  meaning synchronous, active-high reset.
REQ-005 SHALL have ports iReq0/iReq1  input  1 each  meaning requester 0 (CPU bus) and requester 1 (secondary master) block-read requests.
REQ-006 SHALL have ports iAddr0/iAddr1  input  32 each  meaning the SD block address of each requester.
REQ-007 SHALL have ports oGnt0/oGnt1  output  1 each  meaning the requester currently owns the SD controller.
REQ-008 SHALL have ports oDone0/oDone1  output  1 each  meaning a one-cycle completion pulse to the owning requester.
REQ-009 SHALL have port oSDRead  output  1  meaning the read strobe to the SD controller (rd).
REQ-010 SHALL have port oSDAddress  output  32  meaning the latched block address driven to the controller.
REQ-011 SHALL have port iSDCtrl  input  4  meaning the controller state code: 0 = ready, 8..B = read in progress.
REQ-012 SHALL have port iWordReady  input  1  meaning a one-cycle pulse, synchronous to iCLK, per 32-bit word stored in the buffer.
REQ-013 SHALL have ports oBusy (output, 1), oWordCount (output, 7) and oError (output, 1), meaning transaction active, words received so far, and watchdog abort.

Function
REQ-014 SHALL implement FSM states IDLE, ISSUE, WAIT_ACK, XFER and DONE; with SD_ARB_TIMEOUT_EN defined, SHALL add state ABORT.
REQ-015 IDLE: sample requests; on any request, grant the winner, latch its address into oSDAddress, clear oWordCount, and go to ISSUE next cycle.
REQ-016 Arbitration SHALL be round-robin: with both requests high, grant the requester not served last; the pointer after reset favours requester 0.
REQ-017 Requests SHALL be sampled only in IDLE; request changes during a transaction SHALL be ignored.
REQ-018 ISSUE: hold oSDRead=0 until iSDCtrl==0, then assert oSDRead=1 and go to WAIT_ACK.
REQ-019 WAIT_ACK: hold oSDRead=1 until iSDCtrl is in 8..B, then drive oSDRead=0 the next cycle and go to XFER.
REQ-020 XFER: increment oWordCount on each iWordReady; a pulse that arrives while oWordCount==WORDS_PER_BLOCK-1 SHALL go to DONE, and oWordCount SHALL wrap to 0.
REQ-021 iWordReady outside XFER SHALL be ignored.
REQ-022 DONE: pulse oDoneN of the owner for exactly one cycle, drop oGntN the same cycle, update the round-robin pointer, and return to IDLE.
REQ-023 At most one oGnt SHALL be high at any time; oBusy SHALL be high in every state except IDLE.
REQ-024 Minimum latency from request to oDone SHALL be 4 cycles plus the controller response time plus WORDS_PER_BLOCK word pulses.

Reset
REQ-025 Reset high SHALL, at the next edge, force IDLE, all oGnt/oDone/oSDRead/oError/oBusy=0, oWordCount=0, oSDAddress=0 and the pointer to favour requester 0; this SHALL apply in any state, including mid-transfer, without producing an oDone pulse.

Configuration
REQ-026 Macro SD_ARB_TIMEOUT_EN defined: a watchdog counter SHALL clear on every state change and on every iWordReady, and reaching TIMEOUT_CYCLES in ISSUE, WAIT_ACK or XFER SHALL enter ABORT.
REQ-027 ABORT: drive oSDRead=0, pulse oDoneN and oError together for one cycle, release the grant, update the pointer, and return to IDLE.
REQ-028 Macro not defined: no watchdog logic and no ABORT state SHALL exist, and oError SHALL be tied to 0 (port retained).

Verification
REQ-029 iReq0=1 with iAddr0=0x00000010 and iSDCtrl=0 -> oGnt0 is high, oSDAddress=0x10 and oSDRead rises; after 128 iWordReady pulses, oDone0 is high for 1 cycle and oWordCount=0.
REQ-030 iReq0 and iReq1 held high together for 3 transactions -> grants are 0, 1, 0 and oGnt0 is never high together with oGnt1.
REQ-031 iSDCtrl=4 while in ISSUE for 10 cycles -> oSDRead stays 0; when iSDCtrl becomes 0 -> oSDRead=1; when iSDCtrl becomes 9 -> oSDRead=0 the next cycle.
REQ-032 Reset asserted after 50 of 128 words -> next cycle: IDLE, oWordCount=0, all outputs 0, no oDone pulse.
REQ-033 With SD_ARB_TIMEOUT_EN and TIMEOUT_CYCLES=16, word pulses stop after 5 -> 16 cycles later oError and oDone1 are high for 1 cycle; without the macro the FSM stays in XFER and oError=0.

Source files
------------

// File: rtl/sd_block_arbiter.sv
// Round-robin arbiter granting one of two requesters a single SD block read.
// Define SD_ARB_TIMEOUT_EN to add the watchdog and its ABORT state.
module sd_block_arbiter #(
  parameter int unsigned WORDS_PER_BLOCK = 128,
  parameter int unsigned TIMEOUT_CYCLES  = 1048576
) (
  input  logic        iCLK,
  input  logic        Reset,
  input  logic        iReq0,
  input  logic        iReq1,
  input  logic [31:0] iAddr0,
  input  logic [31:0] iAddr1,
  output logic        oGnt0,
  output logic        oGnt1,
  output logic        oDone0,
  output logic        oDone1,
  output logic        oSDRead,
  output logic [31:0] oSDAddress,
  input  logic [3:0]  iSDCtrl,
  input  logic        iWordReady,
  output logic        oBusy,
  output logic [6:0]  oWordCount,
  output logic        oError
);

  if (WORDS_PER_BLOCK < 1 || WORDS_PER_BLOCK > 128) begin : g_words_range
    $error("WORDS_PER_BLOCK must be in 1..128 to fit oWordCount");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_timeout_range
    $error("TIMEOUT_CYCLES must be at least 2");
  end

`ifdef SD_ARB_TIMEOUT_EN
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, XFER, DONE, ABORT} state_t;
`else
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_ACK, XFER, DONE} state_t;
`endif

  localparam logic [6:0] LAST_WORD = 7'(WORDS_PER_BLOCK - 1);

  state_t      state_q, state_d;
  logic        gnt0_q, gnt0_d;
  logic        gnt1_q, gnt1_d;
  logic        owner_q, owner_d;
  logic        last_q, last_d;
  logic        rd_q, rd_d;
  logic [31:0] addr_q, addr_d;
  logic [6:0]  cnt_q, cnt_d;
  logic        pick1;
  logic        ctrl_reading;

`ifdef SD_ARB_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  logic [WD_W-1:0] wd_q, wd_d;
  logic            wd_active;
`endif

  // last_q is the requester served last; reset value 1 favours requester 0
  assign pick1        = iReq1 && (!iReq0 || !last_q);
  assign ctrl_reading = (iSDCtrl[3:2] == 2'b10);

  always_comb begin
    state_d = state_q;
    gnt0_d  = gnt0_q;
    gnt1_d  = gnt1_q;
    owner_d = owner_q;
    last_d  = last_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (iReq0 || iReq1) begin
          owner_d = pick1;
          gnt0_d  = !pick1;
          gnt1_d  = pick1;
          addr_d  = pick1 ? iAddr1 : iAddr0;
          cnt_d   = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (iSDCtrl == 4'h0) begin
          rd_d    = 1'b1;
          state_d = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        if (ctrl_reading) begin
          rd_d    = 1'b0;
          state_d = XFER;
        end
      end
      XFER: begin
        if (iWordReady) begin
          if (cnt_q == LAST_WORD) begin
            cnt_d   = '0;
            gnt0_d  = 1'b0;
            gnt1_d  = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + 7'd1;
          end
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
`ifdef SD_ARB_TIMEOUT_EN
      ABORT: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase

`ifdef SD_ARB_TIMEOUT_EN
    // A cycle that makes progress (state change or word) never times out
    wd_active = (state_q == ISSUE) || (state_q == WAIT_ACK) || (state_q == XFER);
    if (wd_active && (state_d == state_q) && !iWordReady && (wd_q == WD_LAST)) begin
      state_d = ABORT;
      rd_d    = 1'b0;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
    end
    if (!wd_active || (state_d != state_q) || iWordReady) begin
      wd_d = '0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
`endif
  end

  always_ff @(posedge iCLK) begin
    if (Reset) begin
      state_q <= IDLE;
      gnt0_q  <= 1'b0;
      gnt1_q  <= 1'b0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      cnt_q   <= '0;
`ifdef SD_ARB_TIMEOUT_EN
      wd_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      gnt0_q  <= gnt0_d;
      gnt1_q  <= gnt1_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
`ifdef SD_ARB_TIMEOUT_EN
      wd_q    <= wd_d;
`endif
    end
  end

  logic finishing;
`ifdef SD_ARB_TIMEOUT_EN
  assign finishing = (state_q == DONE) || (state_q == ABORT);
  assign oError    = (state_q == ABORT);
`else
  assign finishing = (state_q == DONE);
  assign oError    = 1'b0;
`endif

  assign oGnt0      = gnt0_q;
  assign oGnt1      = gnt1_q;
  assign oDone0     = finishing && !owner_q;
  assign oDone1     = finishing && owner_q;
  assign oSDRead    = rd_q;
  assign oSDAddress = addr_q;
  assign oWordCount = cnt_q;
  assign oBusy      = (state_q != IDLE);

endmodule

// File: tb/tb_sd_block_arbiter.sv
// Directed bench for sd_block_arbiter: a scoreboard queue of expected
// completions is drained by a monitor watching oDone0/oDone1.
module tb_sd_block_arbiter;

  logic        iCLK = 1'b0;
  logic        Reset = 1'b1;
  logic        iReq0 = 1'b0, iReq1 = 1'b0;
  logic [31:0] iAddr0 = '0, iAddr1 = '0;
  logic [3:0]  iSDCtrl = 4'h0;
  logic        iWordReady = 1'b0;
  logic        oGnt0, oGnt1, oDone0, oDone1, oSDRead, oBusy, oError;
  logic [31:0] oSDAddress;
  logic [6:0]  oWordCount;

  sd_block_arbiter #(.WORDS_PER_BLOCK(128), .TIMEOUT_CYCLES(16)) dut (
    .iCLK(iCLK), .Reset(Reset),
    .iReq0(iReq0), .iReq1(iReq1), .iAddr0(iAddr0), .iAddr1(iAddr1),
    .oGnt0(oGnt0), .oGnt1(oGnt1), .oDone0(oDone0), .oDone1(oDone1),
    .oSDRead(oSDRead), .oSDAddress(oSDAddress), .iSDCtrl(iSDCtrl),
    .iWordReady(iWordReady), .oBusy(oBusy), .oWordCount(oWordCount),
    .oError(oError)
  );

  always #5 iCLK = ~iCLK;

  int n_cmp = 0;
  int n_fail = 0;

  typedef struct {
    logic        id;
    logic [31:0] addr;
    logic        err;
    logic [6:0]  cnt;
  } exp_t;
  exp_t exp_q[$];
  exp_t mon_e;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic tick();
    @(posedge iCLK);
    #1;
  endtask

  task automatic expect_txn(input logic id, input logic [31:0] addr, input logic err,
                            input logic [6:0] cnt);
    exp_t e;
    e.id = id; e.addr = addr; e.err = err; e.cnt = cnt;
    exp_q.push_back(e);
  endtask

  task automatic send_words(input int n);
    for (int i = 0; i < n; i++) begin
      iWordReady = 1'b1;
      tick();
      iWordReady = 1'b0;
      tick();
    end
  endtask

  task automatic wait_drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 20) begin
      tick();
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic run_txn(input logic [1:0] exp_gnt, input string name);
    int t = 0;
    while (!oBusy && t < 10) begin
      tick();
      t++;
    end
    check({name, "_busy"}, oBusy, 1);
    check({name, "_grant"}, {oGnt1, oGnt0}, exp_gnt);
    iSDCtrl = 4'h0;
    t = 0;
    while (!oSDRead && t < 10) begin
      tick();
      t++;
    end
    check({name, "_rd"}, oSDRead, 1);
    iSDCtrl = 4'h9;
    tick();
    send_words(128);
  endtask

  // Completion monitor and per-cycle grant exclusivity
  always @(negedge iCLK) begin
    check("gnt_mutex", oGnt0 & oGnt1, 0);
    if (oDone0 || oDone1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", {oDone1, oDone0}, 2'b00);
      end else begin
        mon_e = exp_q.pop_front();
        check("done_id", {oDone1, oDone0}, mon_e.id ? 2'b10 : 2'b01);
        check("done_addr", oSDAddress, mon_e.addr);
        check("done_err", oError, mon_e.err);
        check("done_gnt_low", {oGnt1, oGnt0}, 2'b00);
        if (!mon_e.err) check("done_wordcount", oWordCount, mon_e.cnt);
      end
    end else begin
      check("err_without_done", oError, 0);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: actual=running required=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    // Reset wins over a pending request
    Reset = 1'b1; iReq0 = 1'b1; iAddr0 = 32'hFFFF_FFFF;
    tick(); tick();
    check("rst_gnt", {oGnt1, oGnt0}, 2'b00);
    check("rst_busy", oBusy, 0);
    check("rst_rd", oSDRead, 0);
    check("rst_addr", oSDAddress, 0);
    check("rst_cnt", oWordCount, 0);
    check("rst_done", {oDone1, oDone0}, 2'b00);
    Reset = 1'b0; iReq0 = 1'b0;
    tick();

    // Single block read from requester 0
    iAddr0 = 32'h0000_0010; iSDCtrl = 4'h0; iReq0 = 1'b1;
    expect_txn(1'b0, 32'h0000_0010, 1'b0, 7'd0);
    tick();
    iReq0 = 1'b0;
    check("t1_gnt", {oGnt1, oGnt0}, 2'b01);
    check("t1_addr", oSDAddress, 32'h10);
    check("t1_rd_issue", oSDRead, 0);
    check("t1_busy", oBusy, 1);
    check("t1_cnt_clr", oWordCount, 0);
    tick();
    check("t1_rd_rise", oSDRead, 1);
    iSDCtrl = 4'h8;
    tick();
    check("t1_rd_fall", oSDRead, 0);
    send_words(127);
    check("t1_cnt_127", oWordCount, 127);
    check("t1_gnt_held", oGnt0, 1);
    send_words(1);
    check("t1_idle", oBusy, 0);
    check("t1_cnt_wrap", oWordCount, 0);
    wait_drain("t1_drain");

    // Requester 1, controller busy in ISSUE, late requests and stray words ignored
    iSDCtrl = 4'h4; iAddr1 = 32'h2000_0ABC; iReq1 = 1'b1;
    expect_txn(1'b1, 32'h2000_0ABC, 1'b0, 7'd0);
    tick();
    iReq1 = 1'b0;
    check("t2_gnt", {oGnt1, oGnt0}, 2'b10);
    check("t2_addr", oSDAddress, 32'h2000_0ABC);
    iWordReady = 1'b1; iReq0 = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      iWordReady = 1'b0;
      check("t2_rd_hold", oSDRead, 0);
    end
    check("t2_word_ignored", oWordCount, 0);
    check("t2_req_ignored", {oGnt1, oGnt0}, 2'b10);
    iReq0 = 1'b0;
    iSDCtrl = 4'h0;
    tick();
    check("t2_rd_rise", oSDRead, 1);
    tick(); tick();
    check("t2_rd_wait_ack", oSDRead, 1);
    iSDCtrl = 4'h9;
    tick();
    check("t2_rd_fall", oSDRead, 0);
    send_words(128);
    check("t2_idle", oBusy, 0);
    wait_drain("t2_drain");

    // Reset after 50 words: no completion, everything cleared
    iAddr0 = 32'h0000_0055; iReq0 = 1'b1; iSDCtrl = 4'h0;
    tick();
    iReq0 = 1'b0;
    check("t3_gnt", {oGnt1, oGnt0}, 2'b01);
    tick();
    iSDCtrl = 4'hA;
    tick();
    send_words(50);
    check("t3_cnt_50", oWordCount, 50);
    Reset = 1'b1;
    tick();
    check("t3_gnt", {oGnt1, oGnt0}, 2'b00);
    check("t3_done", {oDone1, oDone0}, 2'b00);
    check("t3_rd", oSDRead, 0);
    check("t3_err", oError, 0);
    check("t3_busy", oBusy, 0);
    check("t3_cnt", oWordCount, 0);
    check("t3_addr", oSDAddress, 0);
    Reset = 1'b0;
    tick(); tick();
    check("t3_stays_idle", oBusy, 0);

    // Both requesting: pointer after reset favours 0, then alternates
    iAddr0 = 32'h0000_00A0; iAddr1 = 32'h0000_00B1;
    expect_txn(1'b0, 32'h0000_00A0, 1'b0, 7'd0);
    expect_txn(1'b1, 32'h0000_00B1, 1'b0, 7'd0);
    expect_txn(1'b0, 32'h0000_00A0, 1'b0, 7'd0);
    iReq0 = 1'b1; iReq1 = 1'b1;
    run_txn(2'b01, "t4_txn0");
    run_txn(2'b10, "t4_txn1");
    run_txn(2'b01, "t4_txn2");
    iReq0 = 1'b0; iReq1 = 1'b0;
    tick();
    check("t4_idle", oBusy, 0);
    wait_drain("t4_drain");

    // Words stop after 5
    iAddr1 = 32'hCAFE_0001; iReq1 = 1'b1; iSDCtrl = 4'h0;
`ifdef SD_ARB_TIMEOUT_EN
    expect_txn(1'b1, 32'hCAFE_0001, 1'b1, 7'd5);
`endif
    tick();
    iReq1 = 1'b0;
    check("t5_gnt", {oGnt1, oGnt0}, 2'b10);
    tick();
    iSDCtrl = 4'hB;
    tick();
    send_words(5);
    check("t5_cnt_5", oWordCount, 5);
`ifdef SD_ARB_TIMEOUT_EN
    begin
      int t = 0;
      while (!oError && t < 40) begin
        tick();
        t++;
      end
      // last word edge plus 16 cycles; send_words already consumed one
      check("t5_abort_latency", t, 15);
      check("t5_abort_done", {oDone1, oDone0}, 2'b10);
      tick();
      check("t5_abort_idle", oBusy, 0);
      check("t5_abort_err_pulse", oError, 0);
      wait_drain("t5_drain");
    end
`else
    repeat (30) tick();
    check("t5_stuck_busy", oBusy, 1);
    check("t5_stuck_gnt", {oGnt1, oGnt0}, 2'b10);
    check("t5_no_err", oError, 0);
    check("t5_cnt_held", oWordCount, 5);
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    check("t5_reset_idle", oBusy, 0);
`endif

    wait_drain("final_drain");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
